mont_mult: RTL and testbench

Radix-2 bit-serial Montgomery multiplier computing R = A·B·2^(−N) mod M for an odd N-bit modulus. It is the downstream consumer of the R/R² constant generator: R_t (2^(2N) mod M) is fed as operand B to convert values into the Montgomery domain, and R_r (2^N mod M) serves as the Montgomery "one". The block is the core multiply step of the RSA decryption exponentiation loop, invoked repeatedly by the exponentiation controller.

---
 rtl/mont_mult.sv | 104 ++++++++++
 tb/tb_mont_mult.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mont_mult.sv
// Radix-2 bit-serial Montgomery multiplier: R = A*B*2^(-N) mod M for odd M.
// One iteration per cycle over the latched A bits, then a single conditional subtract.
module mont_mult #(
    parameter int unsigned N = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] M,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOP,
        S_FINAL,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  m_q, m_d;
    logic [N-1:0]  r_q, r_d;
    logic [N+1:0]  s_q, s_d;
    logic [N+1:0]  t_add, t_red;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            r_q     <= r_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        r_d     = r_q;
        s_d     = s_q;
        cnt_d   = cnt_q;

        // a_q is shifted right each iteration so its LSB is always the current a_i.
        t_add = s_q + (a_q[0] ? {2'b00, b_q} : '0);
        t_red = t_add[0] ? (t_add + {2'b00, m_q}) : t_add;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    m_d     = M;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                s_d   = t_red >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                r_d     = (s_q >= {2'b00, m_q}) ? N'(s_q - {2'b00, m_q}) : s_q[N-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign R    = r_q;
    assign busy = (state_q == S_LOOP) || (state_q == S_FINAL);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mont_mult.sv
// Directed bench for mont_mult: an 8-bit instance for protocol/boundary cases
// and a 1024-bit instance for the RSA-sized round trip.
module tb_mont_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, start8, busy8, done8;
    logic [7:0] a8, b8, m8, r8;

    logic          rst1k, start1k, busy1k, done1k;
    logic [1023:0] a1k, b1k, m1k, r1k;

    int total = 0;
    int bad   = 0;

    mont_mult #(.N(8)) dut8 (
        .clk(clk), .reset(rst8), .start(start8),
        .A(a8), .B(b8), .M(m8),
        .R(r8), .busy(busy8), .done(done8)
    );

    mont_mult #(.N(1024)) dut1k (
        .clk(clk), .reset(rst1k), .start(start1k),
        .A(a1k), .B(b1k), .M(m1k),
        .R(r1k), .busy(busy1k), .done(done1k)
    );

    // Starts an 8-bit op, scrambles the input ports after acceptance, and waits for done.
    // lat = edges after the accepting edge until done is seen; busy_n = cycles busy was high.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_n);
        @(negedge clk);
        a8 = a; b8 = b; m8 = 8'd239; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'hFF; b8 = 8'hAA; m8 = 8'h10;
        busy_n = busy8 ? 1 : 0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy8) busy_n++;
            if (done8) break;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst8 = 1'b1; start8 = 1'b1; a8 = 8'd5; b8 = 8'd7; m8 = 8'd239;
        rst1k = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (r8 !== 8'd0) begin bad++; $display("FAIL reset_R8 got=%0d exp=0", r8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy8_with_start got=%b exp=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        total++; if (r1k !== '0 || busy1k !== 1'b0 || done1k !== 1'b0) begin
            bad++; $display("FAIL reset_1k R0=%b busy=%b done=%b exp all zero", (r1k == '0), busy1k, done1k);
        end
        start8 = 1'b0; rst8 = 1'b0; rst1k = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bn;
        run8(8'd5, 8'd7, lat, bn);
        total++; if (r8 !== 8'd227) begin bad++; $display("FAIL basic_R got=%0d exp=227", r8); end
        total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        total++; if (bn !== 9) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=9", bn); end
        // start during the DONE cycle must be dropped
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd17; m8 = 8'd239;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", done8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL start_in_done_ignored busy=%b exp=0", busy8); end
        total++; if (r8 !== 8'd227) begin bad++; $display("FAIL R_hold got=%0d exp=227", r8); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vr [3];
        int lat, bn;
        va = '{8'd5, 8'd1, 8'd0};
        vb = '{8'd50, 8'd17, 8'd200};
        vr = '{8'd85, 8'd1, 8'd0};
        for (int i = 0; i < 3; i++) begin
            run8(va[i], vb[i], lat, bn);
            total++; if (r8 !== vr[i]) begin bad++; $display("FAIL conv_R[%0d] got=%0d exp=%0d", i, r8, vr[i]); end
            total++; if (lat !== 9) begin bad++; $display("FAIL conv_latency[%0d] got=%0d exp=9", i, lat); end
        end
    endtask

    task automatic test_final_sub_ignore;
        int dones;
        @(negedge clk);
        a8 = 8'd238; b8 = 8'd238; m8 = 8'd239; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 3) begin start8 = 1'b1; a8 = 8'd5; b8 = 8'd7; end
            if (i == 4) start8 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (done8) dones++;
        end
        total++; if (r8 !== 8'd225) begin bad++; $display("FAIL final_sub_R got=%0d exp=225", r8); end
        total++; if (dones !== 1) begin bad++; $display("FAIL busy_start_ignored done_pulses got=%0d exp=1", dones); end
    endtask

    task automatic test_reset_mid;
        int dones, lat, bn;
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd7; m8 = 8'd239; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        total++; if (r8 !== 8'd0) begin bad++; $display("FAIL midreset_R got=%0d exp=0", r8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", done8); end
        dones = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL midreset_no_done pulses=%0d exp=0", dones); end
        run8(8'd5, 8'd7, lat, bn);
        total++; if (r8 !== 8'd227) begin bad++; $display("FAIL after_reset_R got=%0d exp=227", r8); end
        total++; if (lat !== 9) begin bad++; $display("FAIL after_reset_latency got=%0d exp=9", lat); end
    endtask

    task automatic test_rsa;
        logic [1023:0] mm, x, rt, xr;
        logic [2048:0] num, den;
        int lat;
        mm  = {16'h57BB, {62{16'hA5C3}}, 16'h80E1};
        x   = {16'h1234, {62{16'h0F1E}}, 16'h2B3D};
        den = {1025'b0, mm};
        num = '0;
        num[2048] = 1'b1;
        num = num % den;
        rt  = num[1023:0];
        num = {1'b0, x, 1024'b0} % den;
        xr  = num[1023:0];

        @(negedge clk);
        a1k = x; b1k = rt; m1k = mm; start1k = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1k = 1'b0;
        a1k = '1; b1k = '1;
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done1k) break;
        end
        total++; if (r1k !== xr) begin bad++; $display("FAIL rsa_to_mont R[63:0]=%h exp[63:0]=%h", r1k[63:0], xr[63:0]); end
        total++; if (lat !== 1025) begin bad++; $display("FAIL rsa_latency got=%0d exp=1025", lat); end

        @(negedge clk);
        a1k = xr; b1k = 1024'd1; start1k = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1k = 1'b0;
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done1k) break;
        end
        total++; if (r1k !== x) begin bad++; $display("FAIL rsa_round_trip R[63:0]=%h exp[63:0]=%h", r1k[63:0], x[63:0]); end
        total++; if (lat !== 1025) begin bad++; $display("FAIL rsa_latency2 got=%0d exp=1025", lat); end
    endtask

    initial begin
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; m8 = 8'd239;
        rst1k = 1'b1; start1k = 1'b0; a1k = '0; b1k = '0; m1k = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_final_sub_ignore();
        test_reset_mid();
        test_rsa();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
